// File: rtl/reset_sequencer_if.sv
// Control inputs and reset/status outputs of the reset sequencer.
// master is the sequencer side; slave is the clock/reset controller or CPU side.
interface reset_sequencer_if;
  logic       pll_locked;
  logic       soft_req;
  logic       wdt_en;
  logic       wdt_kick;
  logic       mem_resetn;
  logic       periph_resetn;
  logic       cpu_resetn;
  logic       ready;
  logic [1:0] cause;

  modport master (
    input  pll_locked,
    input  soft_req,
    input  wdt_en,
    input  wdt_kick,
    output mem_resetn,
    output periph_resetn,
    output cpu_resetn,
    output ready,
    output cause
  );

  modport slave (
    output pll_locked,
    output soft_req,
    output wdt_en,
    output wdt_kick,
    input  mem_resetn,
    input  periph_resetn,
    input  cpu_resetn,
    input  ready,
    input  cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases the memory, peripheral and CPU reset domains in order once the PLL is stable.
// Handles lock loss, CPU soft reset and a watchdog, and records the last reset cause.
module reset_sequencer #(
  parameter int unsigned          LOCK_FILTER = 16,
  parameter int unsigned          STAGE_DELAY = 64,
  parameter int unsigned          WDT_WIDTH   = 24,
  parameter logic [WDT_WIDTH-1:0] WDT_LIMIT   = {WDT_WIDTH{1'b1}}
) (
  input logic               clk,
  input logic               RESET,
  reset_sequencer_if.master rs_io
);

  // Counters only ever hold limit-1 before the event fires and clears them.
  localparam int unsigned LockW  = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int unsigned StageW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;

  localparam logic [LockW-1:0]  LockLast  = LockW'(LOCK_FILTER - 1);
  localparam logic [StageW-1:0] StageLast = StageW'(STAGE_DELAY - 1);

  localparam logic [1:0] CauseRst  = 2'd0;
  localparam logic [1:0] CauseLock = 2'd1;
  localparam logic [1:0] CauseSoft = 2'd2;
  localparam logic [1:0] CauseWdt  = 2'd3;

  typedef enum logic [2:0] {
    StWaitLock,
    StDlyMem,
    StDlyPeriph,
    StDlyCpu,
    StRun
  } state_e;

  state_e               state_q, state_d;
  logic [LockW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [StageW-1:0]    stage_cnt_q, stage_cnt_d;
  logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
  logic                 mem_rstn_q, mem_rstn_d;
  logic                 periph_rstn_q, periph_rstn_d;
  logic                 cpu_rstn_q, cpu_rstn_d;
  logic                 ready_q, ready_d;
  logic [1:0]           cause_q, cause_d;

  logic lock_loss;
  logic wdt_expire;
  logic soft_hit;
  logic stage_done;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q       <= StWaitLock;
      lock_cnt_q    <= '0;
      stage_cnt_q   <= '0;
      wdt_cnt_q     <= '0;
      mem_rstn_q    <= 1'b0;
      periph_rstn_q <= 1'b0;
      cpu_rstn_q    <= 1'b0;
      ready_q       <= 1'b0;
      cause_q       <= CauseRst;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      stage_cnt_q   <= stage_cnt_d;
      wdt_cnt_q     <= wdt_cnt_d;
      mem_rstn_q    <= mem_rstn_d;
      periph_rstn_q <= periph_rstn_d;
      cpu_rstn_q    <= cpu_rstn_d;
      ready_q       <= ready_d;
      cause_q       <= cause_d;
    end
  end

  always_comb begin
    lock_loss  = !rs_io.pll_locked && (state_q != StWaitLock);
    wdt_expire = (state_q == StRun) && rs_io.wdt_en && !rs_io.wdt_kick &&
                 (wdt_cnt_q == WDT_LIMIT);
    soft_hit   = (state_q == StRun) && rs_io.soft_req;
    stage_done = (stage_cnt_q == StageLast);
  end

  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = '0;
    stage_cnt_d   = stage_cnt_q;
    wdt_cnt_d     = '0;
    mem_rstn_d    = mem_rstn_q;
    periph_rstn_d = periph_rstn_q;
    cpu_rstn_d    = cpu_rstn_q;
    ready_d       = ready_q;
    cause_d       = cause_q;

    // Event priority below RESET: lock loss, then watchdog, then soft request.
    if (lock_loss || wdt_expire) begin
      state_d       = StWaitLock;
      stage_cnt_d   = '0;
      mem_rstn_d    = 1'b0;
      periph_rstn_d = 1'b0;
      cpu_rstn_d    = 1'b0;
      ready_d       = 1'b0;
      cause_d       = lock_loss ? CauseLock : CauseWdt;
    end else if (soft_hit) begin
      // Memory contents survive a soft reset; only downstream domains restart.
      state_d       = StDlyPeriph;
      stage_cnt_d   = '0;
      periph_rstn_d = 1'b0;
      cpu_rstn_d    = 1'b0;
      ready_d       = 1'b0;
      cause_d       = CauseSoft;
    end else begin
      unique case (state_q)
        StWaitLock: begin
          stage_cnt_d = '0;
          if (rs_io.pll_locked) begin
            if (lock_cnt_q == LockLast) begin
              state_d = StDlyMem;
            end else begin
              lock_cnt_d = lock_cnt_q + 1'b1;
            end
          end
        end
        StDlyMem: begin
          if (stage_done) begin
            stage_cnt_d = '0;
            mem_rstn_d  = 1'b1;
            state_d     = StDlyPeriph;
          end else begin
            stage_cnt_d = stage_cnt_q + 1'b1;
          end
        end
        StDlyPeriph: begin
          if (stage_done) begin
            stage_cnt_d   = '0;
            periph_rstn_d = 1'b1;
            state_d       = StDlyCpu;
          end else begin
            stage_cnt_d = stage_cnt_q + 1'b1;
          end
        end
        StDlyCpu: begin
          if (stage_done) begin
            stage_cnt_d = '0;
            cpu_rstn_d  = 1'b1;
            ready_d     = 1'b1;
            state_d     = StRun;
          end else begin
            stage_cnt_d = stage_cnt_q + 1'b1;
          end
        end
        StRun: begin
          stage_cnt_d = '0;
          if (rs_io.wdt_en && !rs_io.wdt_kick) begin
            wdt_cnt_d = (wdt_cnt_q == WDT_LIMIT) ? wdt_cnt_q : wdt_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d       = StWaitLock;
          stage_cnt_d   = '0;
          mem_rstn_d    = 1'b0;
          periph_rstn_d = 1'b0;
          cpu_rstn_d    = 1'b0;
          ready_d       = 1'b0;
        end
      endcase
    end
  end

  assign rs_io.mem_resetn    = mem_rstn_q;
  assign rs_io.periph_resetn = periph_rstn_q;
  assign rs_io.cpu_resetn    = cpu_rstn_q;
  assign rs_io.ready         = ready_q;
  assign rs_io.cause         = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed and random stimulus for reset_sequencer, checked every cycle against a
// timeline model: domain releases are derived from cycles elapsed since sequencing began.
module tb_reset_sequencer;
  localparam int unsigned LF  = 3;
  localparam int unsigned D   = 4;
  localparam int unsigned WW  = 24;
  localparam int unsigned LIM = 10;

  logic clk;
  logic rst;

  reset_sequencer_if rs_if ();

  reset_sequencer #(
    .LOCK_FILTER (LF),
    .STAGE_DELAY (D),
    .WDT_WIDTH   (WW),
    .WDT_LIMIT   (WW'(LIM))
  ) dut (
    .clk   (clk),
    .RESET (rst),
    .rs_io (rs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: sequencing active, consecutive locked cycles, elapsed sequencing time.
  bit         m_seq;
  int         m_lock_run;
  int         m_t;
  int         m_wdt;
  logic [1:0] m_cause;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_assert++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit in_run;
    in_run = m_seq && (m_t >= 3 * D);
    if (rst) begin
      m_seq = 0; m_lock_run = 0; m_t = 0; m_wdt = 0; m_cause = 2'd0;
    end else if (m_seq && !rs_if.pll_locked) begin
      m_seq = 0; m_lock_run = 0; m_t = 0; m_wdt = 0; m_cause = 2'd1;
    end else if (in_run && rs_if.wdt_en && !rs_if.wdt_kick && m_wdt == LIM) begin
      m_seq = 0; m_lock_run = 0; m_t = 0; m_wdt = 0; m_cause = 2'd3;
    end else if (in_run && rs_if.soft_req) begin
      m_t = D; m_wdt = 0; m_cause = 2'd2;
    end else if (!m_seq) begin
      if (rs_if.pll_locked) begin
        m_lock_run++;
        if (m_lock_run == LF) begin
          m_seq = 1; m_t = 0; m_lock_run = 0;
        end
      end else begin
        m_lock_run = 0;
      end
    end else if (!in_run) begin
      m_t++;
    end else begin
      m_wdt = (rs_if.wdt_en && !rs_if.wdt_kick) ? ((m_wdt < LIM) ? m_wdt + 1 : LIM) : 0;
    end
  endtask

  task automatic check_all();
    logic e_mem, e_per, e_cpu;
    e_mem = m_seq && (m_t >= D);
    e_per = m_seq && (m_t >= 2 * D);
    e_cpu = m_seq && (m_t >= 3 * D);
    chk("mem_resetn", rs_if.mem_resetn, e_mem);
    chk("periph_resetn", rs_if.periph_resetn, e_per);
    chk("cpu_resetn", rs_if.cpu_resetn, e_cpu);
    chk("ready", rs_if.ready, e_cpu);
    chk("cause", rs_if.cause, m_cause);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      check_all();
    end
  endtask

  initial begin
    int e_mem, e_per, e_cpu;
    m_seq = 0; m_lock_run = 0; m_t = 0; m_wdt = 0; m_cause = 2'd0;
    rst = 1'b1;
    rs_if.pll_locked = 1'b0;
    rs_if.soft_req   = 1'b0;
    rs_if.wdt_en     = 1'b0;
    rs_if.wdt_kick   = 1'b0;
    #1;

    // Reset state, then nominal bring-up with release edges recorded.
    step(2);
    rst = 1'b0;
    rs_if.pll_locked = 1'b1;
    e_mem = 0; e_per = 0; e_cpu = 0;
    for (int e = 1; e <= 16; e++) begin
      step(1);
      if (e_mem == 0 && rs_if.mem_resetn === 1'b1) e_mem = e;
      if (e_per == 0 && rs_if.periph_resetn === 1'b1) e_per = e;
      if (e_cpu == 0 && rs_if.ready === 1'b1) e_cpu = e;
    end
    chk_int("mem_release_edge", e_mem, LF + D);
    chk_int("periph_release_edge", e_per, LF + 2 * D);
    chk_int("cpu_release_edge", e_cpu, LF + 3 * D);

    // Lock glitch restarts the filter.
    rst = 1'b1; rs_if.pll_locked = 1'b0; step(1);
    rst = 1'b0; rs_if.pll_locked = 1'b1; step(2);
    rs_if.pll_locked = 1'b0; step(1);
    rs_if.pll_locked = 1'b1;
    e_mem = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1);
      if (e_mem == 0 && rs_if.mem_resetn === 1'b1) e_mem = e;
    end
    chk_int("glitch_mem_edge", e_mem, LF + D);
    step(10);

    // Lock loss in RUN, then full re-sequence.
    rs_if.pll_locked = 1'b0; step(1);
    chk("lockloss_cause", rs_if.cause, 2'd1);
    rs_if.pll_locked = 1'b1; step(LF + 3 * D + 2);

    // Soft reset from RUN.
    rs_if.soft_req = 1'b1; step(1);
    rs_if.soft_req = 1'b0;
    chk("soft_mem_kept", rs_if.mem_resetn, 1'b1);
    step(3 * D);

    // Watchdog expiry with no kicks.
    rs_if.wdt_en = 1'b1; step(LIM + 1);
    chk("wdt_cause", rs_if.cause, 2'd3);
    chk("wdt_mem", rs_if.mem_resetn, 1'b0);
    step(LF + 3 * D);

    // Kick every 8 cycles keeps RUN alive.
    for (int i = 0; i < 100; i++) begin
      rs_if.wdt_kick = (i % 8 == 7);
      step(1);
    end
    chk("wdt_kick_ready", rs_if.ready, 1'b1);

    // Kick on the expiry cycle wins.
    rs_if.wdt_kick = 1'b1; step(1);
    rs_if.wdt_kick = 1'b0; step(LIM);
    rs_if.wdt_kick = 1'b1; step(1);
    rs_if.wdt_kick = 1'b0; step(3);
    chk("wdt_expiry_kick_ready", rs_if.ready, 1'b1);
    rs_if.wdt_en = 1'b0; step(2);

    // Soft request and lock loss together: lock loss wins.
    rs_if.soft_req = 1'b1; rs_if.pll_locked = 1'b0; step(1);
    rs_if.soft_req = 1'b0; rs_if.pll_locked = 1'b1;
    chk("soft_vs_lock_cause", rs_if.cause, 2'd1);
    chk("soft_vs_lock_mem", rs_if.mem_resetn, 1'b0);

    // RESET in the middle of DLY_PERIPH.
    step(LF + D + 2);
    rst = 1'b1; step(1);
    chk("midseq_rst_cause", rs_if.cause, 2'd0);
    chk("midseq_rst_mem", rs_if.mem_resetn, 1'b0);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 399) == 0);
      rs_if.pll_locked = ($urandom_range(0, 79) != 0);
      rs_if.soft_req   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) rs_if.wdt_en = ~rs_if.wdt_en;
      rs_if.wdt_kick   = ($urandom_range(0, 6) == 0);
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
